// File: rtl/kcpsmx3_inc.sv
// Shared definitions for the ALU execute stage.
//   OPERAND_WIDTH : data width of operands and results
//   opcode_t      : ALU operation select (codes 11..15 are unencoded/illegal)
//   shift_op_t    : fill-bit source for single-bit shifts
//   odd_parity()  : helper used by the TEST operation
package kcpsmx3_inc;

  localparam int OPERAND_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_LOAD    = 4'd0,
    OP_AND     = 4'd1,
    OP_OR      = 4'd2,
    OP_XOR     = 4'd3,
    OP_TEST    = 4'd4,
    OP_ADD     = 4'd5,
    OP_ADDCY   = 4'd6,
    OP_SUB     = 4'd7,
    OP_SUBCY   = 4'd8,
    OP_COMPARE = 4'd9,
    OP_SHIFT   = 4'd10
  } opcode_t;

  typedef enum logic [1:0] {
    SH_CONST  = 2'd0,
    SH_EXTEND = 2'd1,
    SH_CARRY  = 2'd2,
    SH_ROTATE = 2'd3
  } shift_op_t;

  function automatic logic odd_parity(input logic [OPERAND_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Request/response bus of the ALU execute stage.
//   in_*  : request descriptor with valid/ready handshake (producer -> stage)
//   out_* : result and flags with valid/ready handshake (stage -> consumer)
// Modports:
//   master : the side that issues requests and consumes results
//   slave  : the execute stage itself
interface alu_exec_stage_if;
  import kcpsmx3_inc::*;

  logic                     in_valid;
  logic                     in_ready;
  opcode_t                  in_opcode;
  shift_op_t                in_shift_op;
  logic                     in_shift_dir;
  logic                     in_shift_const;
  logic                     in_carry_in;
  logic [OPERAND_WIDTH-1:0] in_operand_a;
  logic [OPERAND_WIDTH-1:0] in_operand_b;

  logic                     out_valid;
  logic                     out_ready;
  logic [OPERAND_WIDTH-1:0] out_result;
  logic                     out_zero;
  logic                     out_carry;
  logic                     out_illegal;

  modport master (
    output in_valid, in_opcode, in_shift_op, in_shift_dir, in_shift_const,
           in_carry_in, in_operand_a, in_operand_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_shift_op, in_shift_dir, in_shift_const,
           in_carry_in, in_operand_a, in_operand_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry, out_illegal
  );

endinterface

// File: rtl/alu_shift_unit.sv
// Combinational single-bit shift/rotate datapath.
// Ports:
//   a           : operand to shift
//   shift_op    : fill source (constant, sign/edge extend, carry, rotate)
//   shift_dir   : 0 = left, 1 = right
//   shift_const : fill bit used by SH_CONST
//   carry_in    : fill bit used by SH_CARRY
//   result      : shifted operand
//   carry_out   : the bit shifted out
module alu_shift_unit
  import kcpsmx3_inc::*;
#(
  parameter int W = OPERAND_WIDTH
) (
  input  logic [W-1:0] a,
  input  shift_op_t    shift_op,
  input  logic         shift_dir,
  input  logic         shift_const,
  input  logic         carry_in,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic fill;

  always_comb begin
    fill = shift_const;
    case (shift_op)
      SH_CONST:  fill = shift_const;
      // Extend replicates the edge bit that the shift moves away from.
      SH_EXTEND: fill = shift_dir ? a[W-1] : a[0];
      SH_CARRY:  fill = carry_in;
      SH_ROTATE: fill = shift_dir ? a[0] : a[W-1];
    endcase

    if (shift_dir) begin
      result    = {fill, a[W-1:1]};
      carry_out = a[0];
    end else begin
      result    = {a[W-2:0], fill};
      carry_out = a[W-1];
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage pipelined ALU execute stage.
// Stage 1 registers the accepted request descriptor; stage 2 holds the
// computed result and flags until the consumer takes it. One op per cycle,
// in order, with back-pressure propagating through in_ready.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, discards in-flight ops
//   bus      : request/response bus (slave side)
//   ops_done : free-running count of completed output handshakes
module alu_exec_stage
  import kcpsmx3_inc::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_exec_stage_if.slave bus,
  output logic [15:0]     ops_done
);

  localparam int W = OPERAND_WIDTH;

  logic            vld_p1;
  opcode_t         opcode_p1;
  shift_op_t       shift_op_p1;
  logic            shift_dir_p1;
  logic            shift_const_p1;
  logic            carry_in_p1;
  logic [W-1:0]    a_p1;
  logic [W-1:0]    b_p1;

  logic            vld_p2;
  logic [W-1:0]    result_p2;
  logic            zero_p2;
  logic            carry_p2;
  logic            illegal_p2;

  logic            adv_p2;
  logic            accept;

  logic [W-1:0]    sh_result;
  logic            sh_carry;
  logic [W:0]      ext;
  logic [W-1:0]    alu_result;
  logic            alu_zero;
  logic            alu_carry;
  logic            alu_illegal;

  // Stage 2 can take new data when empty or when its content leaves now.
  assign adv_p2       = !vld_p2 || bus.out_ready;
  assign bus.in_ready = !reset && (!vld_p1 || adv_p2);
  assign accept       = bus.in_valid && bus.in_ready;

  // ---- stage 0 -> 1: descriptor capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (bus.in_ready) begin
      vld_p1 <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opcode_p1      <= bus.in_opcode;
      shift_op_p1    <= bus.in_shift_op;
      shift_dir_p1   <= bus.in_shift_dir;
      shift_const_p1 <= bus.in_shift_const;
      carry_in_p1    <= bus.in_carry_in;
      a_p1           <= bus.in_operand_a;
      b_p1           <= bus.in_operand_b;
    end
  end

  // ---- stage 1 compute: shift datapath and arithmetic/logic ----
  alu_shift_unit #(.W(W)) u_shift (
    .a           (a_p1),
    .shift_op    (shift_op_p1),
    .shift_dir   (shift_dir_p1),
    .shift_const (shift_const_p1),
    .carry_in    (carry_in_p1),
    .result      (sh_result),
    .carry_out   (sh_carry)
  );

  always_comb begin
    ext         = '0;
    alu_result  = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (opcode_p1)
      OP_LOAD: begin
        alu_result = b_p1;
        alu_carry  = carry_in_p1;
      end
      OP_AND:  alu_result = a_p1 & b_p1;
      OP_OR:   alu_result = a_p1 | b_p1;
      OP_XOR:  alu_result = a_p1 ^ b_p1;
      OP_TEST: begin
        alu_result = a_p1 & b_p1;
        alu_carry  = odd_parity(a_p1 & b_p1);
      end
      OP_ADD: begin
        ext        = {1'b0, a_p1} + {1'b0, b_p1};
        alu_result = ext[W-1:0];
        alu_carry  = ext[W];
      end
      OP_ADDCY: begin
        ext        = {1'b0, a_p1} + {1'b0, b_p1} + {{W{1'b0}}, carry_in_p1};
        alu_result = ext[W-1:0];
        alu_carry  = ext[W];
      end
      // For subtraction the extra top bit of the widened difference is the borrow.
      OP_SUB: begin
        ext        = {1'b0, a_p1} - {1'b0, b_p1};
        alu_result = ext[W-1:0];
        alu_carry  = ext[W];
      end
      OP_SUBCY: begin
        ext        = {1'b0, a_p1} - {1'b0, b_p1} - {{W{1'b0}}, carry_in_p1};
        alu_result = ext[W-1:0];
        alu_carry  = ext[W];
      end
      OP_COMPARE: begin
        alu_result = a_p1;
        alu_carry  = (a_p1 < b_p1);
      end
      OP_SHIFT: begin
        alu_result = sh_result;
        alu_carry  = sh_carry;
      end
      default: alu_illegal = 1'b1;
    endcase

    // Compare reports operand equality; illegal ops never flag zero.
    if (opcode_p1 == OP_COMPARE) begin
      alu_zero = (a_p1 == b_p1);
    end else begin
      alu_zero = !alu_illegal && (alu_result == '0);
    end
  end

  // ---- stage 1 -> 2: result register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
    end
  end

  // Result registers are cleared so the output bus reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p2  <= '0;
      zero_p2    <= 1'b0;
      carry_p2   <= 1'b0;
      illegal_p2 <= 1'b0;
    end else if (adv_p2 && vld_p1) begin
      result_p2  <= alu_result;
      zero_p2    <= alu_zero;
      carry_p2   <= alu_carry;
      illegal_p2 <= alu_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ops_done <= '0;
    end else if (vld_p2 && bus.out_ready) begin
      ops_done <= ops_done + 16'd1;
    end
  end

  assign bus.out_valid   = vld_p2;
  assign bus.out_result  = result_p2;
  assign bus.out_zero    = zero_p2;
  assign bus.out_carry   = carry_p2;
  assign bus.out_illegal = illegal_p2;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases, back-pressure,
// reset during traffic, randomized traffic against a behavioural model,
// and ops_done wrap-around.
module tb_alu_exec_stage;
  import kcpsmx3_inc::*;

  localparam int W    = OPERAND_WIDTH;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int r;
    int z;
    int c;
    int ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ops_done;

  alu_exec_stage_if bus();

  alu_exec_stage dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   exp_ops;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the operation rules.
  function automatic exp_t model(input int op, input int a, input int b, input int cin,
                                 input int sop, input int dir, input int cst);
    exp_t e;
    int   fill;
    int   msb;
    e.r = 0; e.c = 0; e.ill = 0;
    msb  = (a >> (W - 1)) & 1;
    fill = 0;
    case (op)
      OP_LOAD:    begin e.r = b; e.c = cin; end
      OP_AND:     e.r = a & b;
      OP_OR:      e.r = a | b;
      OP_XOR:     e.r = a ^ b;
      OP_TEST:    begin e.r = a & b; e.c = $countones(a & b) % 2; end
      OP_ADD:     begin e.r = a + b; e.c = (e.r > MASK) ? 1 : 0; end
      OP_ADDCY:   begin e.r = a + b + cin; e.c = (e.r > MASK) ? 1 : 0; end
      OP_SUB:     begin e.r = a - b; e.c = (a < b) ? 1 : 0; end
      OP_SUBCY:   begin e.r = a - b - cin; e.c = (a < b + cin) ? 1 : 0; end
      OP_COMPARE: begin e.r = a; e.c = (a < b) ? 1 : 0; end
      OP_SHIFT: begin
        if (dir == 0) begin
          case (sop)
            SH_CONST:  fill = cst;
            SH_EXTEND: fill = a & 1;
            SH_CARRY:  fill = cin;
            default:   fill = msb;
          endcase
          e.r = (a << 1) | fill;
          e.c = msb;
        end else begin
          case (sop)
            SH_CONST:  fill = cst;
            SH_EXTEND: fill = msb;
            SH_CARRY:  fill = cin;
            default:   fill = a & 1;
          endcase
          e.r = (a >> 1) | (fill << (W - 1));
          e.c = a & 1;
        end
      end
      default: e.ill = 1;
    endcase
    e.r = e.r & MASK;
    if (op == OP_COMPARE) e.z = (a == b) ? 1 : 0;
    else if (e.ill != 0)  e.z = 0;
    else                  e.z = (e.r == 0) ? 1 : 0;
    return e;
  endfunction

  // Scoreboard: handshakes are observed on the falling edge, ahead of the
  // rising edge that completes them.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      exp_ops = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_val("result",  bus.out_result,  e.r);
          check_val("zero",    bus.out_zero,    e.z);
          check_val("carry",   bus.out_carry,   e.c);
          check_val("illegal", bus.out_illegal, e.ill);
        end
        check_val("ops_done", ops_done, exp_ops);
        exp_ops = (exp_ops + 1) & 16'hFFFF;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.in_opcode), int'(bus.in_operand_a),
                              int'(bus.in_operand_b), int'(bus.in_carry_in),
                              int'(bus.in_shift_op), int'(bus.in_shift_dir),
                              int'(bus.in_shift_const)));
      end
    end
  end

  task automatic set_inputs(input int op, input int a, input int b, input int cin,
                            input int sop, input int dir, input int cst);
    bus.in_opcode      = opcode_t'(op[3:0]);
    bus.in_operand_a   = a[W-1:0];
    bus.in_operand_b   = b[W-1:0];
    bus.in_carry_in    = cin[0];
    bus.in_shift_op    = shift_op_t'(sop[1:0]);
    bus.in_shift_dir   = dir[0];
    bus.in_shift_const = cst[0];
  endtask

  // All tasks start and end one time unit after a rising edge.
  task automatic send(input int op, input int a, input int b, input int cin,
                      input int sop, input int dir, input int cst);
    bit ok;
    ok = 1'b0;
    set_inputs(op, a, b, cin, sop, dir, cst);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      check_val("send_timeout", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send($urandom_range(0, 15), $urandom_range(0, MASK), $urandom_range(0, MASK),
         $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
         $urandom_range(0, 1));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!done) check_val("drain_timeout", bus.out_valid | (exp_q.size() != 0), 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_one(input string tag, input int op, input int a, input int b,
                         input int cin, input int sop, input int dir, input int cst,
                         input int er, input int ez, input int ec, input int eill);
    int lat;
    bus.out_ready = 1'b1;
    set_inputs(op, a, b, cin, sop, dir, cst);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_val({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, lat,             2);
    check_val({tag, "_result"},  bus.out_result,  er);
    check_val({tag, "_zero"},    bus.out_zero,    ez);
    check_val({tag, "_carry"},   bus.out_carry,   ec);
    check_val({tag, "_illegal"}, bus.out_illegal, eill);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e0;
    bit   sdone;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid",  bus.out_valid,   0);
    check_val("rst_out_result", bus.out_result,  0);
    check_val("rst_out_zero",   bus.out_zero,    0);
    check_val("rst_out_carry",  bus.out_carry,   0);
    check_val("rst_out_illegal", bus.out_illegal, 0);
    check_val("rst_ops_done",   ops_done,        0);
    check_val("idle_in_ready",  bus.in_ready,    1);
    @(posedge clk); #1;

    // Directed operations with known answers.
    run_one("add_ff01",  OP_ADD,     'hFF, 'h01, 0, 0, 0, 0,          'h00, 1, 1, 0);
    run_one("subcy_eq",  OP_SUBCY,   'h10, 'h10, 1, 0, 0, 0,          'hFF, 0, 1, 0);
    run_one("cmp_eq",    OP_COMPARE, 'h05, 'h05, 0, 0, 0, 0,          'h05, 1, 0, 0);
    run_one("shr_ext",   OP_SHIFT,   'h81, 'h00, 0, SH_EXTEND, 1, 0,  'hC0, 0, 1, 0);
    run_one("shl_rot",   OP_SHIFT,   'h80, 'h00, 0, SH_ROTATE, 0, 0,  'h01, 0, 1, 0);
    run_one("shl_carry", OP_SHIFT,   'h40, 'h00, 1, SH_CARRY,  0, 0,  'h81, 0, 0, 0);
    run_one("test_par",  OP_TEST,    'h0F, 'h07, 0, 0, 0, 0,          'h07, 0, 1, 0);
    run_one("addcy_ovf", OP_ADDCY,   'h7F, 'h80, 1, 0, 0, 0,          'h00, 1, 1, 0);
    run_one("illegal",   12,         'h33, 'h44, 1, 0, 0, 0,          'h00, 0, 0, 1);

    // Back-pressure: two ops fill the pipe, third is held off.
    do_reset();
    bus.out_ready = 1'b0;
    e0 = model(OP_ADD, 'h12, 'h34, 0, 0, 0, 0);
    send(OP_ADD, 'h12, 'h34, 0, 0, 0, 0);
    send(OP_XOR, 'hF0, 'h3C, 0, 0, 0, 0);
    set_inputs(OP_SUB, 'h05, 'h09, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_in_ready",  bus.in_ready,   0);
      check_val("stall_out_valid", bus.out_valid,  1);
      check_val("stall_result",    bus.out_result, e0.r);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(OP_SUB, 'h05, 'h09, 0, 0, 0, 0);
    send(OP_OR,  'h00, 'h00, 0, 0, 0, 0);
    drain();
    @(negedge clk);
    check_val("stall_ops_done", ops_done, 4);
    @(posedge clk); #1;

    // Reset with both stages full, plus a request offered during reset.
    bus.out_ready = 1'b0;
    send(OP_LOAD, 0, 'hA5, 1, 0, 0, 0);
    send(OP_AND, 'hFF, 'h0F, 0, 0, 0, 0);
    set_inputs(OP_LOAD, 0, 'h5A, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_req_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("flush_out_valid", bus.out_valid,  0);
    check_val("flush_ops_done",  ops_done,       0);
    check_val("flush_result",    bus.out_result, 0);
    check_val("flush_carry",     bus.out_carry,  0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("flush_no_ghost", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    run_one("post_rst", OP_SUB, 'h03, 'h01, 0, 0, 0, 0, 'h02, 0, 0, 0);
    @(negedge clk);
    check_val("post_rst_ops_done", ops_done, 1);
    @(posedge clk); #1;

    // Randomized traffic with random consumer stalls.
    sdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_rand();
        end
        sdone = 1'b1;
      end
      begin
        while (!sdone) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Counter wrap: 65535 handshakes, then one more.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send_rand();
    drain();
    @(negedge clk);
    check_val("ops_done_max", ops_done, 16'hFFFF);
    @(posedge clk); #1;
    send_rand();
    drain();
    @(negedge clk);
    check_val("ops_done_wrap", ops_done, 16'h0000);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
